// File: rtl/shift_feeder_4094.sv
// Feeds bytes from a valid/ready producer to a CD4094 shift-register driver and generates its wr_en strobe.
// Latency: byte accepted into an empty FIFO at edge E is loaded with sr_rd_en at E+1; backpressure via in_ready when FIFO is full.
module shift_feeder_4094 #(
    parameter int CLK_DIV    = 6,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            sr_state,
    output logic                  sr_rd_en,
    output logic [7:0]            sr_data,
    output logic                  sr_wr_en,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  busy,
    output logic                  err
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ARM   = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [1:0]            state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [7:0]            data_q, data_d;
    logic                  err_q, err_d;
    logic                  push, pop;

    assign in_ready = (level_q != LVL_FULL);
    assign push     = in_valid && in_ready;

    // Strobe divider runs regardless of dispatch activity.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        wr_en_d = wr_en_q ^ (div_q == DIV_LAST);
    end

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0 && sr_state == 2'd0) begin
                    state_d = ST_ISSUE;
                    rd_en_d = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            ST_ARM: begin
                // Driver still idle one cycle after the load pulse: it missed the byte.
                if (sr_state != 2'd0) begin
                    state_d = ST_WAIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: if (sr_state == 2'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            rd_en_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            wr_en_q  <= wr_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
    end

    assign sr_rd_en   = rd_en_q;
    assign sr_data    = data_q;
    assign sr_wr_en   = wr_en_q;
    assign fifo_level = level_q;
    assign busy       = (level_q != '0) || (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_shift_feeder_4094.sv
// Bench for shift_feeder_4094 with a behavioural CD4094 driver model and a byte-order scoreboard.
module tb_shift_feeder_4094;

    localparam int CLK_DIV    = 6;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [1:0]          sr_state = 2'd0;
    logic                sr_rd_en;
    logic [7:0]          sr_data;
    logic                sr_wr_en;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                busy;
    logic                err;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] iss_q[$];
    bit         bits_q[$];

    // Driver model: 0 normal, 1 forced busy, 2 deaf (never leaves idle).
    int         drv_mode = 0;
    bit         drv_held = 0;
    logic [7:0] drv_sh = 8'h00;
    int         drv_bits = 0;
    int         drv_done = 0;
    bit         wr_prev = 0;
    bit         rd_prev = 0;
    bit         wr_rise;
    int         viol_cnt = 0;
    int         dbl_cnt = 0;

    shift_feeder_4094 #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sr_state(sr_state), .sr_rd_en(sr_rd_en), .sr_data(sr_data), .sr_wr_en(sr_wr_en),
        .fifo_level(fifo_level), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sr_rd_en) begin
            iss_q.push_back(sr_data);
            if (sr_state != 2'd0) viol_cnt++;
            if (rd_prev) dbl_cnt++;
        end
        rd_prev = sr_rd_en;
        wr_rise = sr_wr_en && !wr_prev;
        wr_prev = sr_wr_en;
        if (drv_mode == 1) begin
            sr_state = 2'd1;
            drv_held = 1;
        end else if (drv_held) begin
            sr_state = 2'd0;
            drv_held = 0;
        end else if (drv_mode == 2) begin
            sr_state = 2'd0;
        end else if (sr_state == 2'd0) begin
            if (sr_rd_en) begin
                drv_sh   = sr_data;
                drv_bits = 0;
                sr_state = 2'd1;
            end
        end else if (wr_rise) begin
            if (drv_bits < 8) begin
                bits_q.push_back(drv_sh[7]);
                drv_sh   = {drv_sh[6:0], 1'b0};
                drv_bits = drv_bits + 1;
                sr_state = 2'd2;
            end else begin
                sr_state = 2'd0;
                drv_done = drv_done + 1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output bit ok);
        bit rdy;
        ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 3000 && !ok; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (iss_q.size() == exp_q.size() && !busy && sr_state == 2'd0) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fifo_level !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (sr_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", sr_wr_en); end
        checks++; if (sr_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", sr_rd_en); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (sr_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", sr_data); end
        rst_n = 1'b1; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        bad = 0;
        for (int k = 1; k <= 4 * CLK_DIV; k++) begin
            @(posedge clk); #1;
            if (sr_wr_en !== 1'((k / CLK_DIV) % 2)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL strobe_timing got=%0d bad_cycles exp=0", bad); end
        checks++; if (fifo_level !== 0) begin failures++; $display("FAIL reset_nothing_pushed got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_single();
        bit ok;
        bit exp_bits[8];
        int bad;
        logic [7:0] b;
        b = 8'hA5;
        bits_q.delete();
        push_byte(b, ok);
        in_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL single_push_timeout got=0 exp=1"); end
        checks++; if (fifo_level !== 1 || sr_rd_en !== 1'b0) begin failures++; $display("FAIL single_after_accept got=lvl%0d/rd%b exp=lvl1/rd0", fifo_level, sr_rd_en); end
        @(posedge clk); #1;
        checks++; if (sr_rd_en !== 1'b1 || sr_data !== b) begin failures++; $display("FAIL single_pulse got=rd%b/%0h exp=rd1/%0h", sr_rd_en, sr_data, b); end
        @(posedge clk); #1;
        checks++; if (sr_rd_en !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", sr_rd_en); end
        wait_drain(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) exp_bits[i] = b[7 - i];
        bad = (bits_q.size() == 8) ? 0 : 1;
        for (int i = 0; i < 8 && bad == 0; i++) if (bits_q[i] != exp_bits[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL single_bits got=%0d bits/%0d mismatches exp=8/0", bits_q.size(), bad); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
        exp_q.delete(); iss_q.delete();
    endtask

    task automatic test_burst();
        bit ok;
        int bad;
        for (int v = 1; v <= 5; v++) begin
            push_byte(8'(v), ok);
            checks++; if (!ok) begin failures++; $display("FAIL burst_push_timeout got=0 exp=1"); end
        end
        checks++; if (fifo_level !== 3'(exp_q.size() - iss_q.size()) || fifo_level !== DEPTH) begin
            failures++; $display("FAIL burst_full_level got=%0d exp=%0d", fifo_level, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL burst_in_ready got=%b exp=0", in_ready); end
        push_byte(8'h06, ok);
        in_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL burst_push6_timeout got=0 exp=1"); end
        wait_drain(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL burst_drain_timeout got=0 exp=1"); end
        bad = (iss_q.size() == 6) ? 0 : 1;
        for (int i = 0; i < 6 && bad == 0; i++) if (iss_q[i] !== 8'(i + 1)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL burst_order got=%0d issued/%0d bad exp=6/0", iss_q.size(), bad); end
        checks++; if (viol_cnt != 0 || dbl_cnt != 0) begin failures++; $display("FAIL burst_rd_while_busy got=%0d/%0d exp=0/0", viol_cnt, dbl_cnt); end
        exp_q.delete(); iss_q.delete();
    endtask

    task automatic test_hold();
        bit ok;
        int pulses, lvl_bad;
        drv_mode = 1;
        push_byte(8'($urandom_range(0, 255)), ok);
        push_byte(8'($urandom_range(0, 255)), ok);
        in_valid = 1'b0;
        pulses = 0; lvl_bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (sr_rd_en) pulses++;
            if (fifo_level !== 3'(exp_q.size())) lvl_bad++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL hold_no_pulse got=%0d exp=0", pulses); end
        checks++; if (lvl_bad != 0 || fifo_level !== 2) begin failures++; $display("FAIL hold_level got=%0d bad=%0d exp=2", fifo_level, lvl_bad); end
        drv_mode = 0;
        // Driver goes idle before the next edge; that edge must start the load.
        @(posedge clk); #1;
        checks++; if (sr_rd_en !== 1'b1 || sr_data !== exp_q[0]) begin failures++; $display("FAIL hold_release_pulse got=rd%b/%0h exp=rd1/%0h", sr_rd_en, sr_data, exp_q[0]); end
        wait_drain(1000, ok);
        checks++; if (!ok || iss_q.size() != 2 || iss_q[1] !== exp_q[1]) begin failures++; $display("FAIL hold_drain got=%0d issued exp=2", iss_q.size()); end
        exp_q.delete(); iss_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        int bad, n;
        n = 5;
        for (int i = 0; i < n; i++) begin
            push_byte(8'($urandom), ok);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
        end
        wait_drain(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL random_drain_timeout got=0 exp=1"); end
        bad = (iss_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < exp_q.size() && bad == 0; i++) if (iss_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL random_order got=%0d issued/%0d bad exp=%0d/0", iss_q.size(), bad, exp_q.size()); end
        checks++; if (err !== 1'b0 || viol_cnt != 0 || dbl_cnt != 0) begin failures++; $display("FAIL random_protocol got=err%b/%0d/%0d exp=err0/0/0", err, viol_cnt, dbl_cnt); end
        exp_q.delete(); iss_q.delete();
    endtask

    task automatic test_err();
        bit ok;
        logic [7:0] z;
        drv_mode = 2;
        push_byte(8'($urandom), ok);
        push_byte(8'($urandom), ok);
        in_valid = 1'b0;
        wait_drain(200, ok);
        checks++; if (!ok || err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
        checks++; if (iss_q.size() != 2 || iss_q[0] !== exp_q[0] || iss_q[1] !== exp_q[1]) begin failures++; $display("FAIL err_next_issued got=%0d issued exp=2", iss_q.size()); end
        drv_mode = 0;
        z = 8'($urandom);
        push_byte(z, ok);
        in_valid = 1'b0;
        wait_drain(400, ok);
        checks++; if (!ok || iss_q.size() != 3 || iss_q[2] !== z) begin failures++; $display("FAIL err_recover got=%0d issued exp=3", iss_q.size()); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
        exp_q.delete(); iss_q.delete();
    endtask

    task automatic test_mid_reset();
        bit ok;
        int v0;
        logic [7:0] n;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), ok);
        in_valid = 1'b0;
        checks++; if (fifo_level !== 3'(exp_q.size() - iss_q.size()) || sr_state == 2'd0) begin
            failures++; $display("FAIL midrst_setup got=lvl%0d/st%0d exp=lvl%0d/busy", fifo_level, sr_state, exp_q.size() - iss_q.size()); end
        rst_n = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        exp_q.delete(); iss_q.delete();
        checks++; if (fifo_level !== 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got=lvl%0d/busy%b exp=lvl0/busy0", fifo_level, busy); end
        checks++; if (err !== 1'b0 || sr_rd_en !== 1'b0) begin failures++; $display("FAIL midrst_err got=err%b/rd%b exp=err0/rd0", err, sr_rd_en); end
        v0 = viol_cnt;
        n = 8'($urandom);
        push_byte(n, ok);
        in_valid = 1'b0;
        wait_drain(400, ok);
        checks++; if (!ok || iss_q.size() != 1 || iss_q[0] !== n) begin failures++; $display("FAIL midrst_new_byte got=%0d issued exp=1", iss_q.size()); end
        checks++; if (viol_cnt != v0 || dbl_cnt != 0) begin failures++; $display("FAIL midrst_rd_while_busy got=%0d exp=%0d", viol_cnt, v0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold();
        test_random();
        test_err();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
